// File: rtl/dmem_arbiter_if.sv
// Requester A/B and data-memory signals of dmem_arbiter, bundled for port connection.
// slave = arbiter view, master = requesters plus memory view.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  // Handshake: x_req and its fields stay stable until x_ready pulses (request accepted).
  // x_done pulses once per accepted request; x_err and x_rdata are meaningful with x_done.
  logic              a_req;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_ready;
  logic              a_done;
  logic              a_err;
  logic [DATA_W-1:0] a_rdata;

  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_ready;
  logic              b_done;
  logic              b_err;
  logic [DATA_W-1:0] b_rdata;

  logic [ADDR_W-1:0] Mem_Addr;
  logic [DATA_W-1:0] Write_Data;
  logic              MemWrite;
  logic              MemRead;
  logic [DATA_W-1:0] Read_Data;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, Read_Data,
    output a_ready, a_done, a_err, a_rdata, b_ready, b_done, b_err, b_rdata,
    output Mem_Addr, Write_Data, MemWrite, MemRead
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, Read_Data,
    input  a_ready, a_done, a_err, a_rdata, b_ready, b_done, b_err, b_rdata,
    input  Mem_Addr, Write_Data, MemWrite, MemRead
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for a single-ported 64-bit data memory: fixed 3-cycle slot, range check.
// Define DMEM_ARB_FIXED_PRIO_EN to make port A win every tie instead of round-robin.
module dmem_arbiter #(
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 64,
  parameter int MEM_BYTES = 64
) (
  input  logic       clk,
  input  logic       reset,
  dmem_arbiter_if.slave bus,
  output logic [1:0] dbg_state
);
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, CAPTURE = 2'd2} state_t;

  localparam logic [ADDR_W-1:0] LAST_OK = ADDR_W'(MEM_BYTES - 8);

  state_t            state, state_d;
  logic              grant_b, grant_b_d;
  logic              op_we, op_we_d;
  logic              op_oor, op_oor_d;
  logic              last_b, last_b_d;
  logic              a_ready_q, a_ready_d, b_ready_q, b_ready_d;
  logic              a_done_q, a_done_d, b_done_q, b_done_d;
  logic              a_err_q, a_err_d, b_err_q, b_err_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              mem_read_q, mem_read_d, mem_write_q, mem_write_d;

  logic              pick_b, sel_we, sel_oor;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  always_comb begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
    pick_b = !bus.a_req;
`else
    // On a tie the port that did not win the previous slot goes next.
    pick_b = bus.b_req && (!bus.a_req || !last_b);
`endif
    sel_we    = pick_b ? bus.b_we    : bus.a_we;
    sel_addr  = pick_b ? bus.b_addr  : bus.a_addr;
    sel_wdata = pick_b ? bus.b_wdata : bus.a_wdata;
    sel_oor   = sel_addr > LAST_OK;
  end

  always_comb begin
    state_d     = state;
    grant_b_d   = grant_b;
    op_we_d     = op_we;
    op_oor_d    = op_oor;
    last_b_d    = last_b;
    a_ready_d   = 1'b0;
    b_ready_d   = 1'b0;
    a_done_d    = 1'b0;
    b_done_d    = 1'b0;
    a_err_d     = 1'b0;
    b_err_d     = 1'b0;
    a_rdata_d   = a_rdata_q;
    b_rdata_d   = b_rdata_q;
    mem_addr_d  = mem_addr_q;
    wdata_d     = wdata_q;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    case (state)
      IDLE: begin
        if (bus.a_req || bus.b_req) begin
          grant_b_d   = pick_b;
          op_we_d     = sel_we;
          op_oor_d    = sel_oor;
          a_ready_d   = !pick_b;
          b_ready_d   = pick_b;
          mem_addr_d  = sel_addr;
          wdata_d     = sel_wdata;
          mem_read_d  = !sel_we && !sel_oor;
          mem_write_d = sel_we && !sel_oor;
          state_d     = ISSUE;
        end
      end
      ISSUE: state_d = CAPTURE;
      CAPTURE: begin
        // Out-of-range ops return zero data; stores leave rdata untouched.
        if (grant_b) begin
          b_done_d = 1'b1;
          b_err_d  = op_oor;
          if (op_oor)      b_rdata_d = '0;
          else if (!op_we) b_rdata_d = bus.Read_Data;
        end else begin
          a_done_d = 1'b1;
          a_err_d  = op_oor;
          if (op_oor)      a_rdata_d = '0;
          else if (!op_we) a_rdata_d = bus.Read_Data;
        end
        last_b_d = grant_b;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      grant_b     <= 1'b0;
      op_we       <= 1'b0;
      op_oor      <= 1'b0;
      last_b      <= 1'b1;
      a_ready_q   <= 1'b0;
      b_ready_q   <= 1'b0;
      a_done_q    <= 1'b0;
      b_done_q    <= 1'b0;
      a_err_q     <= 1'b0;
      b_err_q     <= 1'b0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
      mem_addr_q  <= '0;
      wdata_q     <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      state       <= state_d;
      grant_b     <= grant_b_d;
      op_we       <= op_we_d;
      op_oor      <= op_oor_d;
      last_b      <= last_b_d;
      a_ready_q   <= a_ready_d;
      b_ready_q   <= b_ready_d;
      a_done_q    <= a_done_d;
      b_done_q    <= b_done_d;
      a_err_q     <= a_err_d;
      b_err_q     <= b_err_d;
      a_rdata_q   <= a_rdata_d;
      b_rdata_q   <= b_rdata_d;
      mem_addr_q  <= mem_addr_d;
      wdata_q     <= wdata_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
    end
  end

  assign bus.a_ready    = a_ready_q;
  assign bus.b_ready    = b_ready_q;
  assign bus.a_done     = a_done_q;
  assign bus.b_done     = b_done_q;
  assign bus.a_err      = a_err_q;
  assign bus.b_err      = b_err_q;
  assign bus.a_rdata    = a_rdata_q;
  assign bus.b_rdata    = b_rdata_q;
  assign bus.Mem_Addr   = mem_addr_q;
  assign bus.Write_Data = wdata_q;
  assign bus.MemRead    = mem_read_q;
  assign bus.MemWrite   = mem_write_q;
  assign dbg_state      = state;
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-ported, byte-addressed 64-bit data memory between two requesters.
- Port A is the core load/store stage; port B is the debug/DMA loader.
- Arbitrates requests, sequences one memory access per slot, and range-checks addresses.
- Returns read data or a write acknowledge to the winning requester with fixed latency.

Parameters:
- ADDR_W, 64, address width on both requester ports and the memory port.
- DATA_W, 64, data width.
- MEM_BYTES, 64, memory size in bytes; a valid access needs addr + 7 <= MEM_BYTES - 1.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- a_req  in  1  port A request; held stable until a_ready.
- a_we  in  1  port A: 1 = store, 0 = load.
- a_addr  in  ADDR_W  port A byte address.
- a_wdata  in  DATA_W  port A store data.
- a_ready  out  1  port A request accepted (1-cycle pulse).
- a_done  out  1  port A transaction complete (1-cycle pulse).
- a_err  out  1  port A out-of-range flag, valid with a_done.
- a_rdata  out  DATA_W  port A load data, valid with a_done when the op was a load.
- b_req, b_we, b_addr, b_wdata, b_ready, b_done, b_err, b_rdata: same as the A signals, for port B.
- Mem_Addr  out  ADDR_W  memory address.
- Write_Data  out  DATA_W  memory write data.
- MemWrite  out  1  memory write enable.
- MemRead  out  1  memory read enable.
- Read_Data  in  DATA_W  memory read data; updated at the edge where MemRead is sampled.

Behaviour:
- All outputs are registered.
- Reset values: every output 0; FSM = IDLE; last_grant = B, so A wins the first tie.
- FSM states: IDLE -> ISSUE -> CAPTURE -> IDLE. Fixed 3-cycle slot; max throughput 1 transaction per 3 cycles.
- Edge E0, in IDLE with any req high:
  - select winner; latch we, addr, wdata and the in-range flag;
  - pulse winner's x_ready for one cycle;
  - drive Mem_Addr/Write_Data; drive MemRead = !we or MemWrite = we, only if in range;
  - go to ISSUE.
  - No req high: stay IDLE, all pulses low.
- Edge E1 (ISSUE): memory performs the access. Drop MemRead/MemWrite; go to CAPTURE. Mem_Addr/Write_Data hold their values.
- Edge E2 (CAPTURE):
  - pulse winner's x_done;
  - loads: x_rdata <= Read_Data; stores: x_rdata holds its previous value;
  - out of range: x_err = 1, x_rdata <= 0, no memory enable was ever asserted;
  - update last_grant; go to IDLE.
- Request sampling:
  - req is sampled only in IDLE; req during ISSUE/CAPTURE is ignored.
  - A req still high at the next IDLE edge is treated as a new request.
- Arbitration:
  - only one req high: that port wins;
  - both high: the port not equal to last_grant wins (round-robin).
- Only one of MemRead/MemWrite is high at any time. Each is high for exactly one cycle per in-range access.
- Range check: addr > MEM_BYTES - 8 (unsigned, full ADDR_W compare, no wrap) is out of range. Unaligned in-range addresses are legal.
- Reset mid-slot: all state clears immediately. A write whose MemWrite has not yet been sampled at E1 is not performed. No x_done is produced for the aborted slot.

Optional Feature:
- Macro: DMEM_ARB_FIXED_PRIO_EN.
- Defined: port A always wins a tie; last_grant is unused.
- Undefined (default): round-robin as described in Behaviour.
- Single-requester behaviour and latency are identical in both builds.

Test Plan:
- Reset, then a_req load, addr 8 -> a_ready 1 cycle later; MemRead high exactly one cycle; a_done + a_rdata = 0x0F0E0D0C0B0A0908 two cycles after a_ready; a_err = 0.
- b_req store, addr 16, wdata 0x1122334455667788; then a_req load, addr 16 -> b_done with b_err = 0; a_rdata = 0x1122334455667788.
- a_req and b_req both high continuously for 4 slots:
  - round-robin build: grant order A, B, A, B;
  - DMEM_ARB_FIXED_PRIO_EN build: A, A, A, A.
- a_req load, addr 57 (MEM_BYTES 64) -> no MemRead pulse; a_done with a_err = 1, a_rdata = 0. Addr 56 -> in range, a_err = 0.
- Store accepted, reset asserted in ISSUE before E1 -> MemWrite drops immediately, no b_done; a later load of the same address returns the old data.
- Back-to-back: a_req held high 6 cycles -> exactly two a_ready pulses 3 cycles apart; no grant while in ISSUE/CAPTURE.
